fp_div: RTL and testbench

Sequential FP16 (IEEE half-precision layout) divider, c = a / b, the inverse operation to the existing FP16 multiplier. It sits beside the multiplier in the MAC datapath for normalisation and scaling steps. It uses an iterative restoring mantissa divider, one quotient bit per cycle, behind a valid/ready handshake on both input and output.

---
 rtl/fp16_pkg.sv | 25 ++
 rtl/fp_div_iter.sv | 58 +++++
 rtl/fp_div.sv | 155 +++++++++++++++
 tb/tb_fp_div.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the multiplier and the divider.
// Holds the format constants and the divider FSM state encoding.
package fp16_pkg;

  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 31;
  localparam int EXP_W        = 5;
  localparam int MAN_W        = 10;

  localparam logic [14:0] FP16_INF_MAG = 15'h7C00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Zero means exponent field zero; denormals flush to zero.
  function automatic logic fp16_is_zero(input logic [15:0] x);
    return (x[MAN_W +: EXP_W] == '0);
  endfunction

endpackage

// File: rtl/fp_div_iter.sv
// Restoring mantissa divider datapath: one quotient bit per enabled cycle.
// Ports:
//   clk, rst   clock / async active-high reset
//   load       capture ma (as initial remainder) and mb, clear quotient
//   en         perform one restoring step
//   ma, mb     11-bit mantissas with hidden bit
//   q          12-bit quotient, MSB weighted 2^0
module fp_div_iter
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [10:0] ma,
  input  logic [10:0] mb,
  output logic [11:0] q
);

  logic [11:0] r_q, r_d;
  logic [11:0] q_q, q_d;
  logic [10:0] mb_q, mb_d;
  logic [11:0] mb_ext;
  logic        ge;

  assign mb_ext = {1'b0, mb_q};
  assign ge     = (r_q >= mb_ext);

  // Remainder stays below 2*mb, so it always fits in 12 bits after the shift.
  always_comb begin
    r_d  = r_q;
    q_d  = q_q;
    mb_d = mb_q;
    if (load) begin
      r_d  = {1'b0, ma};
      q_d  = '0;
      mb_d = mb;
    end else if (en) begin
      r_d = ge ? 12'((r_q - mb_ext) << 1) : 12'(r_q << 1);
      q_d = {q_q[10:0], ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      q_q  <= '0;
      mb_q <= '0;
    end else begin
      r_q  <= r_d;
      q_q  <= q_d;
      mb_q <= mb_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fp_div.sv
// Sequential FP16 divider c = a / b with valid/ready on both sides.
// IDLE -> CALC (12 restoring steps) -> NORM -> DONE -> IDLE; latency is
// data-independent because special cases still run through the datapath.
// Ports:
//   clk, rst             clock / async active-high reset
//   in_valid, in_ready   operand handshake (in_ready only in IDLE)
//   a, b                 FP16 dividend / divisor
//   out_valid, out_ready result handshake (held until accepted)
//   c                    FP16 quotient (truncated)
//   flags                {dz, ovf, unf}
module fp_div
  import fp16_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic [2:0]  flags
);

  div_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               s_q, s_d;
  logic signed [6:0]  e_q, e_d;
  logic               az_q, az_d;
  logic               bz_q, bz_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        c_q, c_d;
  logic [2:0]         flags_q, flags_d;

  logic               accept;
  logic [11:0]        q;
  logic signed [6:0]  exp_n;
  logic [9:0]         mant_n;
  logic [15:0]        res_c;
  logic [2:0]         res_f;

  // in_ready_q is high exactly in IDLE.
  assign accept = in_valid & in_ready_q;

  fp_div_iter u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state_q == ST_CALC),
    .ma   ({1'b1, a[MAN_W-1:0]}),
    .mb   ({1'b1, b[MAN_W-1:0]}),
    .q    (q)
  );

  // Quotient lies in (0.5, 2): q[11] set means no renormalising shift needed.
  assign exp_n  = q[11] ? e_q : e_q - 7'sd1;
  assign mant_n = q[11] ? q[10:1] : q[9:0];

  always_comb begin
    res_c = {s_q, exp_n[EXP_W-1:0], mant_n};
    res_f = 3'b000;
    if (az_q && bz_q) begin
      res_c = FP16_QNAN;
      res_f = 3'b100;
    end else if (bz_q) begin
      res_c = {s_q, FP16_INF_MAG};
      res_f = 3'b100;
    end else if (az_q) begin
      res_c = 16'h0000;
    end else if (exp_n >= $signed(7'(FP16_EXP_MAX))) begin
      res_c = {s_q, FP16_INF_MAG};
      res_f = 3'b010;
    end else if (exp_n <= 7'sd0) begin
      res_c = 16'h0000;
      res_f = 3'b001;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    e_d         = e_q;
    az_d        = az_q;
    bz_d        = bz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    flags_d     = flags_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d    = ST_CALC;
        cnt_d      = '0;
        s_d        = a[15] ^ b[15];
        e_d        = $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]})
                     + $signed(7'(FP16_BIAS));
        az_d       = fp16_is_zero(a);
        bz_d       = fp16_is_zero(b);
        in_ready_d = 1'b0;
      end
      ST_CALC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        c_d         = res_c;
        flags_d     = res_f;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_q         <= 1'b0;
      e_q         <= '0;
      az_q        <= 1'b0;
      bz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      e_q         <= e_d;
      az_q        <= az_d;
      bz_q        <= bz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div.sv
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] c;
  logic [2:0]  flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_div #(.ITER(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value-level division with the documented rules.
  function automatic logic [18:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, ma, mb, q, e, m;
    logic s;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    if (ex == 0 && ey == 0) return {3'b100, 16'h7E00};
    if (ey == 0) return {3'b100, s, 15'h7C00};
    if (ex == 0) return {3'b000, 16'h0000};
    ma = 1024 + int'(x[9:0]);
    mb = 1024 + int'(y[9:0]);
    q  = (ma * 2048) / mb;
    e  = ex - ey + 15;
    if (q >= 2048) m = (q / 2) % 1024;
    else begin m = q % 1024; e = e - 1; end
    if (e >= 31) return {3'b010, s, 15'h7C00};
    if (e <= 0) return {3'b001, 16'h0000};
    return {3'b000, s, 5'(e), 10'(m)};
  endfunction

  // Issue one operation with out_ready high; lat counts edges from the
  // acceptance edge up to and including the edge that raises out_valid.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                        output logic [15:0] rc, output logic [2:0] rf, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    op_a = xa; op_b = xb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    rc = c; rf = flags;
    @(negedge clk);
    chk("in_ready_after_accept", 32'(in_ready), 32'd1);
  endtask

  task automatic dir(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                     input logic [15:0] ec, input logic [2:0] ef);
    logic [15:0] rc; logic [2:0] rf; int lat;
    logic [18:0] r;
    run_op(xa, xb, rc, rf, lat);
    r = ref_div(xa, xb);
    chk({tag, "_c"}, 32'(rc), 32'(ec));
    chk({tag, "_flags"}, 32'(rf), 32'(ef));
    chk({tag, "_model"}, 32'({rf, rc}), 32'(r));
    chk({tag, "_lat"}, lat, 14);
  endtask

  initial begin
    logic [15:0] rc, held;
    logic [2:0]  rf;
    logic [18:0] r;
    int lat, guard;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(negedge clk); rst = 1'b0;

    dir("identity", 16'h3C00, 16'h3C00, 16'h3C00, 3'b000);
    dir("neg2_half", 16'hC000, 16'h3800, 16'hC400, 3'b000);
    dir("6_3", 16'h4600, 16'h4200, 16'h4000, 3'b000);
    dir("third", 16'h3C00, 16'h4200, 16'h3555, 3'b000);
    dir("div0", 16'h3C00, 16'h0000, 16'h7C00, 3'b100);
    dir("negdiv0", 16'hBC00, 16'h0000, 16'hFC00, 3'b100);
    dir("zero_zero", 16'h0000, 16'h0000, 16'h7E00, 3'b100);
    dir("zero_num", 16'h8000, 16'h3C00, 16'h0000, 3'b000);
    dir("ovf", 16'h7BFF, 16'h0400, 16'h7C00, 3'b010);
    dir("unf", 16'h0400, 16'h7800, 16'h0000, 3'b001);
    dir("exp_edge_lo", 16'h0400, 16'h3C00, 16'h0400, 3'b000);
    dir("exp_edge_lo_unf", 16'h0400, 16'h3E00, 16'h0000, 3'b001);

    // Back-pressure: result must hold and new operands be ignored.
    @(negedge clk);
    op_a = 16'h4600; op_b = 16'h4200; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h3C00; op_b = 16'h0000;
    guard = 0;
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    held = c;
    chk("hold_first_c", 32'(held), 32'h4000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c !== held || in_ready !== 1'b0 || out_valid !== 1'b1 || i % 5 == 0) begin
        chk("hold_c", 32'(c), 32'(held));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_out_valid_stay", 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset during iteration.
    op_a = 16'h4600; op_b = 16'h4200; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1; #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (16) @(negedge clk);
    chk("midrst_no_output", 32'(out_valid), 32'd0);
    dir("post_rst_identity", 16'h3C00, 16'h3C00, 16'h3C00, 3'b000);

    // Reset while holding a result.
    @(negedge clk);
    op_a = 16'h4600; op_b = 16'h4200; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("done_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1; #1;
    chk("donerst_out_valid", 32'(out_valid), 32'd0);
    chk("donerst_c", 32'(c), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Random operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] xa, xb;
      xa = 16'($urandom);
      xb = 16'($urandom);
      if (i % 3 == 0) begin
        xa[14:10] = 5'($urandom_range(10, 20));
        xb[14:10] = 5'($urandom_range(10, 20));
      end
      run_op(xa, xb, rc, rf, lat);
      r = ref_div(xa, xb);
      chk($sformatf("rand%0d_%h_%h", i, xa, xb), 32'({rf, rc}), 32'(r));
      chk($sformatf("rand%0d_lat", i), lat, 14);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
